cpu_mem_arbiter: RTL and testbench
==================================

# cpu_mem_arbiter

Arbitrates the CPU's single memory port between the instruction-fetch path (driven by the program counter) and the load/store data path. Holds at most one memory transaction in flight and routes each read response back to the requester that issued it. Drops instruction responses made stale by a taken jump. Data requests take priority, and a starvation limit guarantees forward progress for fetch.

## Interface
- STARVE_LIMIT, 4: maximum consecutive data grants while `ireq` is pending before one fetch is forced through (1..15).
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ireq  in  1  fetch request; held with `iaddr` stable until `iack`
- iaddr  in  32  fetch address (word aligned)
- iack  out  1  fetch request accepted this cycle
- ivalid  out  1  fetch data valid
- irdata  out  32  fetch data
- iflush  in  1  taken jump; invalidates any accepted, unreturned fetch
- dreq  in  1  data request; held with attributes stable until `dack`
- dwrite  in  1  1 = store, 0 = load
- daddr  in  32  data address
- dwdata  in  32  store data
- dwstrb  in  4  store byte enables
- dack  out  1  data request accepted this cycle
- dvalid  out  1  load data valid
- drdata  out  32  load data
- mreq  out  1  memory request; held until `mack`
- mwrite, maddr, mwdata, mwstrb  out  1/32/32/4  memory request attributes, registered
- mack  in  1  memory accepted request this cycle
- mrvalid  in  1  memory read data valid; never asserted for writes
- mrdata  in  32  memory read data

## Operation
The arbiter has three states: IDLE, REQ and WAIT.
- **IDLE:**
  - If `dreq` is asserted and the starvation counter is below STARVE_LIMIT (or `ireq` is low), grant data.
  - Otherwise, if `ireq` is asserted, grant fetch.
  - A grant pulses `iack` or `dack` combinationally, latches the request into the `m*` registers and the owner flag (I/D), and moves to REQ.
- **REQ:**
  - `mreq` = 1.
  - On `mack`, a write returns to IDLE and a read goes to WAIT.
- **WAIT:**
  - On `mrvalid`, return to IDLE.
  - `ivalid`/`dvalid` = `mrvalid` & owner match & not discarded.
  - `irdata`/`drdata` = `mrdata` passthrough; their value is don't-care when the valid is low.
- **Starvation counter (4 bits):**
  - Increments on a data grant while `ireq` = 1.
  - Clears on any fetch grant, and on any grant while `ireq` = 0.
- **Discard flag:**
  - Set when `iflush` = 1 while owner = I in REQ or WAIT.
  - Set when `iflush` = 1 coincides with the `iack` cycle.
  - Cleared on entry to IDLE.
  - A discarded fetch still completes on the bus, but `ivalid` stays 0.
- `iflush` in IDLE without a grant has no effect.
- The arbiter never issues a new `mreq` while a read is outstanding.
- Reset:
  - state = IDLE; `mreq`, `iack`, `dack`, `ivalid`, `dvalid` = 0.
  - `maddr`, `mwdata` = 0; `mwstrb` = 0; `mwrite` = 0; counter = 0; discard = 0.
  - An `mrvalid` arriving in IDLE, including just after a reset mid-transaction, is ignored.

## Timing
- Grant to `mreq`: 1 cycle (`iack`/`dack` in cycle N, `mreq` from N+1).
- `mack` may arrive in the first `mreq` cycle; `mreq` deasserts the cycle after `mack`.
- `mrvalid` is no earlier than the cycle after `mack`.
- Response latency from `mrvalid` to `ivalid`/`dvalid`: 0 cycles (combinational).
- Next grant: earliest the cycle after `mack` (write) or after `mrvalid` (read).
- Minimum back-to-back read throughput: one transaction per 3 cycles.
- `ireq` and `dreq` asserted together in IDLE: data wins unless counter = STARVE_LIMIT.
- `iflush` and `mrvalid` in the same WAIT cycle: `ivalid` = 0.

## Configuration
- `MEM_ARB_PERF_EN` defined adds three outputs, each a 32-bit wrapping counter zeroed on reset:
  - `perf_igrant`: fetch grants.
  - `perf_dgrant`: data grants.
  - `perf_conflict`: IDLE cycles with both `ireq` and `dreq` high.
- Without the macro, those ports and counters are absent and behaviour is otherwise identical.

## Test plan
- **Single fetch:**
  - Stimulus: `ireq`, `iaddr` = 0xFFFF0000 at cycle 0; `mack` at cycle 1; `mrvalid` with `mrdata` = 0x12345678 at cycle 3.
  - Required: `iack` @0; `mreq`/`maddr` = 0xFFFF0000 @1; `ivalid`, `irdata` = 0x12345678 @3.
- **Simultaneous requests:**
  - Stimulus: `ireq` and `dreq` (load 0x100) together; immediate `mack`, `mrvalid` one cycle later.
  - Required: `dack` first with `maddr` = 0x100; `iack` on the next IDLE cycle.
- **Starvation:**
  - Stimulus: STARVE_LIMIT = 4; `dreq` and `ireq` held high continuously.
  - Required: grant order D,D,D,D,I,D,D,D,D,I.
- **Flush during WAIT:**
  - Stimulus: fetch accepted; `iflush` pulsed after `mack`; `mrvalid` arrives.
  - Required: `ivalid` never asserted; next grant the following cycle.
- **Store:**
  - Stimulus: `dwrite` = 1, `daddr` = 0x200, `dwdata` = 0xDEADBEEF, `dwstrb` = 0x3; `mack` in the first `mreq` cycle.
  - Required: `m*` fields match; no `dvalid`; IDLE next cycle.
- **Reset mid-operation:**
  - Stimulus: reset asserted in WAIT; `mrvalid` pulsed after reset.
  - Required: `mreq` = 0; no `ivalid`/`dvalid`; counters = 0.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store, one transaction in flight.
// Optional build macro MEM_ARB_PERF_EN adds grant/conflict performance counters.
module cpu_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic        iack,
    output logic        ivalid,
    output logic [31:0] irdata,
    input  logic        iflush,
    input  logic        dreq,
    input  logic        dwrite,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwstrb,
    output logic        dack,
    output logic        dvalid,
    output logic [31:0] drdata,
    output logic        mreq,
    output logic        mwrite,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [3:0]  mwstrb,
    input  logic        mack,
    input  logic        mrvalid,
    input  logic [31:0] mrdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_igrant,
    output logic [31:0] perf_dgrant,
    output logic [31:0] perf_conflict
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_discard_nxt;
    logic        r_owner_i;
    logic        r_discard;
    logic [3:0]  r_starve;
    logic        r_mwrite;
    logic [31:0] r_maddr;
    logic [31:0] r_mwdata;
    logic [3:0]  r_mwstrb;

    // Grant selection and next-state decode; grants are suppressed while reset is held
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (reset) begin
                    w_grant_d = 1'b0;
                end else if (dreq && (!ireq || (r_starve < LIMIT))) begin
                    w_grant_d = 1'b1;
                end else if (ireq) begin
                    w_grant_i = 1'b1;
                end else begin
                    w_grant_d = 1'b0;
                end
                if (w_grant_i || w_grant_d) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mack) begin
                    w_state_nxt = r_mwrite ? ST_IDLE : ST_WAIT;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mrvalid) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A jump invalidates the fetch being accepted or already on the bus; IDLE entry forgets it
    always_comb begin
        w_discard_nxt = r_discard;
        if (w_state_nxt == ST_IDLE) begin
            w_discard_nxt = 1'b0;
        end else if (iflush && (w_grant_i || (r_owner_i && (r_state != ST_IDLE)))) begin
            w_discard_nxt = 1'b1;
        end else begin
            w_discard_nxt = r_discard;
        end
    end

    // State, owner and discard registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_owner_i <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
            if (w_grant_i || w_grant_d) begin
                r_owner_i <= w_grant_i;
            end
        end
    end

    // Latch the granted request's attributes onto the memory port
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mwrite <= 1'b0;
            r_maddr  <= 32'h0000_0000;
            r_mwdata <= 32'h0000_0000;
            r_mwstrb <= 4'h0;
        end else if (w_grant_d) begin
            r_mwrite <= dwrite;
            r_maddr  <= daddr;
            r_mwdata <= dwdata;
            r_mwstrb <= dwstrb;
        end else if (w_grant_i) begin
            r_mwrite <= 1'b0;
            r_maddr  <= iaddr;
            r_mwdata <= 32'h0000_0000;
            r_mwstrb <= 4'h0;
        end
    end

    // Starvation counter: counts data grants that overtook a waiting fetch
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve <= 4'd0;
        end else if (w_grant_d && ireq) begin
            r_starve <= r_starve + 4'd1;
        end else if (w_grant_i || w_grant_d) begin
            r_starve <= 4'd0;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_igrant;
    logic [31:0] r_perf_dgrant;
    logic [31:0] r_perf_conflict;

    // Free-running wrapping performance counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_igrant   <= 32'd0;
            r_perf_dgrant   <= 32'd0;
            r_perf_conflict <= 32'd0;
        end else begin
            r_perf_igrant   <= r_perf_igrant + {31'd0, w_grant_i};
            r_perf_dgrant   <= r_perf_dgrant + {31'd0, w_grant_d};
            r_perf_conflict <= r_perf_conflict +
                               {31'd0, (r_state == ST_IDLE) && ireq && dreq};
        end
    end

    assign perf_igrant   = r_perf_igrant;
    assign perf_dgrant   = r_perf_dgrant;
    assign perf_conflict = r_perf_conflict;
`endif

    assign iack   = w_grant_i;
    assign dack   = w_grant_d;
    assign mreq   = (r_state == ST_REQ);
    assign mwrite = r_mwrite;
    assign maddr  = r_maddr;
    assign mwdata = r_mwdata;
    assign mwstrb = r_mwstrb;
    // A flush landing with the response also kills it
    assign ivalid = mrvalid && (r_state == ST_WAIT) && r_owner_i && !r_discard && !iflush;
    assign dvalid = mrvalid && (r_state == ST_WAIT) && !r_owner_i;
    assign irdata = mrdata;
    assign drdata = mrdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: fetch, load, store, starvation, flush and reset cases.
module tb_cpu_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ireq, iflush, dreq, dwrite, mack, mrvalid;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic [3:0]  dwstrb;
    logic        iack, ivalid, dack, dvalid, mreq, mwrite;
    logic [31:0] irdata, drdata, maddr, mwdata;
    logic [3:0]  mwstrb;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_igrant, perf_dgrant, perf_conflict;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cpu_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .iack(iack), .ivalid(ivalid), .irdata(irdata),
        .iflush(iflush),
        .dreq(dreq), .dwrite(dwrite), .daddr(daddr), .dwdata(dwdata), .dwstrb(dwstrb),
        .dack(dack), .dvalid(dvalid), .drdata(drdata),
        .mreq(mreq), .mwrite(mwrite), .maddr(maddr), .mwdata(mwdata), .mwstrb(mwstrb),
        .mack(mack), .mrvalid(mrvalid), .mrdata(mrdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_igrant(perf_igrant), .perf_dgrant(perf_dgrant), .perf_conflict(perf_conflict)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One fetch: c0 request, c1 mack, gap idle WAIT cycles, then mrvalid; iflush pulsed in cycle flush_cyc
    task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] data,
                             input int flush_cyc, input int gap, input logic exp_v,
                             input string tag);
        ireq = 1'b1; iaddr = addr; iflush = (flush_cyc == 0);
        #2;
        chk({tag, "_iack"}, iack, 1'b1);
        tick();
        ireq = 1'b0; mack = 1'b1; iflush = (flush_cyc == 1);
        #2;
        chk({tag, "_mreq"}, mreq, 1'b1);
        chk({tag, "_maddr"}, maddr, addr);
        for (int g = 0; g < gap; g++) begin
            tick();
            mack = 1'b0; iflush = (flush_cyc == 2 + g);
            #2;
            chk({tag, "_wait_ivalid"}, ivalid, 1'b0);
        end
        tick();
        mack = 1'b0; mrvalid = 1'b1; mrdata = data; iflush = (flush_cyc == 2 + gap);
        #2;
        chk({tag, "_ivalid"}, ivalid, exp_v);
        if (exp_v) chk({tag, "_irdata"}, irdata, data);
        tick();
        mrvalid = 1'b0; iflush = 1'b0;
    endtask

    // Both requesters held high for n reads; fmask bit k = 1 means grant k must go to fetch
    task automatic arb_seq(input int n, input logic [15:0] fmask, input string tag);
        dreq = 1'b1; dwrite = 1'b0; daddr = 32'h0000_0400; ireq = 1'b1; iaddr = 32'h0000_1000;
        for (int k = 0; k < n; k++) begin
            #2;
            chk({tag, "_iack"}, iack, fmask[k]);
            chk({tag, "_dack"}, dack, !fmask[k]);
            tick();
            mack = 1'b1;
            #2;
            chk({tag, "_maddr"}, maddr, fmask[k] ? 32'h0000_1000 : 32'h0000_0400);
            tick();
            mack = 1'b0; mrvalid = 1'b1; mrdata = 32'hC0DE_0000 + k;
            #2;
            chk({tag, "_ivalid"}, ivalid, fmask[k]);
            chk({tag, "_dvalid"}, dvalid, !fmask[k]);
            tick();
            mrvalid = 1'b0;
        end
        dreq = 1'b0; ireq = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ireq = 1'b1; dreq = 1'b1; iflush = 1'b0; dwrite = 1'b0;
        iaddr = 32'h0000_0010; daddr = 32'h0000_0020; dwdata = 32'h0; dwstrb = 4'h0;
        mack = 1'b0; mrvalid = 1'b0; mrdata = 32'h0;
        tick(); tick();
        #2;
        chk("rst_iack", iack, 1'b0);
        chk("rst_dack", dack, 1'b0);
        chk("rst_mreq", mreq, 1'b0);
        chk("rst_maddr", maddr, 32'h0);
        chk("rst_mwdata", mwdata, 32'h0);
        chk("rst_mwstrb", mwstrb, 4'h0);
        chk("rst_mwrite", mwrite, 1'b0);
        tick();
        reset = 1'b0; ireq = 1'b0; dreq = 1'b0;

        // Single fetch with mrvalid two cycles after mack
        fetch_txn(32'hFFFF_0000, 32'h1234_5678, -1, 1, 1'b1, "fetch");

        // Simultaneous requests: data first, fetch on the next IDLE cycle
        ireq = 1'b1; iaddr = 32'h0000_0040; dreq = 1'b1; dwrite = 1'b0; daddr = 32'h0000_0100;
        #2;
        chk("sim_dack", dack, 1'b1);
        chk("sim_iack0", iack, 1'b0);
        tick();
        dreq = 1'b0; mack = 1'b1;
        #2;
        chk("sim_maddr_d", maddr, 32'h0000_0100);
        chk("sim_iack_req", iack, 1'b0);
        tick();
        mack = 1'b0; mrvalid = 1'b1; mrdata = 32'hAABB_CCDD;
        #2;
        chk("sim_dvalid", dvalid, 1'b1);
        chk("sim_drdata", drdata, 32'hAABB_CCDD);
        chk("sim_ivalid0", ivalid, 1'b0);
        tick();
        mrvalid = 1'b0;
        #2;
        chk("sim_iack", iack, 1'b1);
        tick();
        ireq = 1'b0; mack = 1'b1;
        #2;
        chk("sim_maddr_i", maddr, 32'h0000_0040);
        tick();
        mack = 1'b0; mrvalid = 1'b1; mrdata = 32'h0BAD_F00D;
        #2;
        chk("sim_ivalid", ivalid, 1'b1);
        chk("sim_dvalid0", dvalid, 1'b0);
        tick();
        mrvalid = 1'b0;

        // Starvation: D,D,D,D,I,D,D,D,D,I
        arb_seq(10, 16'b0000_0010_0001_0000, "starve");

        // Flush while waiting for the response; next grant the following cycle
        fetch_txn(32'h0000_0080, 32'h0000_0055, 2, 1, 1'b0, "flush_wait");
        dreq = 1'b1; dwrite = 1'b0; daddr = 32'h0000_0300;
        #2;
        chk("flush_next_dack", dack, 1'b1);
        tick();
        dreq = 1'b0; mack = 1'b1;
        tick();
        mack = 1'b0; mrvalid = 1'b1; mrdata = 32'h0000_0077;
        #2;
        chk("flush_next_dvalid", dvalid, 1'b1);
        chk("flush_next_drdata", drdata, 32'h0000_0077);
        tick();
        mrvalid = 1'b0;

        // Flush with iack, in REQ, and together with mrvalid; then a clean fetch
        fetch_txn(32'h0000_00C0, 32'h0000_0001, 0, 0, 1'b0, "flush_ack");
        fetch_txn(32'h0000_00C4, 32'h0000_0002, 1, 0, 1'b0, "flush_req");
        fetch_txn(32'h0000_00C8, 32'h0000_0003, 2, 0, 1'b0, "flush_rv");
        fetch_txn(32'h0000_00CC, 32'h0000_0004, -1, 0, 1'b1, "post_flush");

        // Store with mack in the first mreq cycle
        dreq = 1'b1; dwrite = 1'b1; daddr = 32'h0000_0200; dwdata = 32'hDEAD_BEEF; dwstrb = 4'h3;
        #2;
        chk("st_dack", dack, 1'b1);
        tick();
        dreq = 1'b0; dwrite = 1'b0; mack = 1'b1;
        #2;
        chk("st_mreq", mreq, 1'b1);
        chk("st_mwrite", mwrite, 1'b1);
        chk("st_maddr", maddr, 32'h0000_0200);
        chk("st_mwdata", mwdata, 32'hDEAD_BEEF);
        chk("st_mwstrb", mwstrb, 4'h3);
        tick();
        mack = 1'b0;
        #2;
        chk("st_mreq_off", mreq, 1'b0);
        chk("st_dvalid", dvalid, 1'b0);
        fetch_txn(32'h0000_0500, 32'h0000_5005, -1, 0, 1'b1, "after_store");

        // Reset while a read is outstanding; a stray mrvalid afterwards is ignored
        dreq = 1'b1; dwrite = 1'b0; daddr = 32'h0000_0100; ireq = 1'b1; iaddr = 32'h0000_0600;
        dwdata = 32'h1111_2222; dwstrb = 4'hF;
        #2;
        chk("rmid_dack", dack, 1'b1);
        tick();
        dreq = 1'b0; mack = 1'b1;
        tick();
        mack = 1'b0; reset = 1'b1;
        tick();
        #2;
        chk("rmid_mreq", mreq, 1'b0);
        chk("rmid_iack", iack, 1'b0);
        chk("rmid_maddr", maddr, 32'h0);
        tick();
        reset = 1'b0; ireq = 1'b0; mrvalid = 1'b1; mrdata = 32'hFEED_0001;
        #2;
        chk("rmid_ivalid", ivalid, 1'b0);
        chk("rmid_dvalid", dvalid, 1'b0);
        chk("rmid_mreq2", mreq, 1'b0);
        tick();
        mrvalid = 1'b0;
        // Counter must restart from zero: D,D,D,D,I
        arb_seq(5, 16'b0000_0000_0001_0000, "rmid_cnt");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
